// File: rtl/mac_pkg.sv
// Shared widths, int8 limits and group-config types for the MAC partial-sum path.
package mac_pkg;

    localparam int ACC_W  = 20;
    localparam int BIAS_W = 16;
    localparam int PSUM_W = 29;
    localparam int OUT_W  = 8;

    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    typedef struct packed {
        logic [4:0] shift;
        logic       relu;
    } rq_cfg_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } acc_state_e;

endpackage

// File: rtl/psum_requant.sv
// Round-half-up arithmetic shift, optional ReLU and int8 saturation of a finished
// partial sum, with the registered output stage.
module psum_requant
    import mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fin_vld_i,
    input  logic signed [PSUM_W-1:0] psum_i,
    input  rq_cfg_t                  cfg_i,
    output logic signed [OUT_W-1:0]  data_o,
    output logic                     vld_o,
    output logic                     ovf_o
);

    localparam int RW = PSUM_W + 1;
    localparam logic signed [RW-1:0]    R_MAX = RW'(INT8_MAX);
    localparam logic signed [RW-1:0]    R_MIN = RW'(INT8_MIN);
    localparam logic signed [OUT_W-1:0] D_MAX = OUT_W'(INT8_MAX);
    localparam logic signed [OUT_W-1:0] D_MIN = OUT_W'(INT8_MIN);

    logic signed [RW-1:0]    rnd;
    logic signed [RW-1:0]    biased;
    logic signed [RW-1:0]    shifted;
    logic signed [OUT_W-1:0] data_d;
    logic                    ovf_d;
    logic signed [OUT_W-1:0] data_q;
    logic                    vld_q;
    logic                    ovf_q;

    // One extra bit of headroom so the rounding add can never wrap.
    always_comb begin
        rnd = '0;
        if (cfg_i.shift != 5'd0) begin
            rnd = RW'(1) << (cfg_i.shift - 5'd1);
        end
        biased  = RW'(psum_i) + rnd;
        shifted = biased >>> cfg_i.shift;
        data_d  = shifted[OUT_W-1:0];
        ovf_d   = 1'b0;
        if (cfg_i.relu && shifted[RW-1]) begin
            data_d = '0;
        end else if (shifted > R_MAX) begin
            data_d = D_MAX;
            ovf_d  = 1'b1;
        end else if (shifted < R_MIN) begin
            data_d = D_MIN;
            ovf_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            vld_q  <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q <= fin_vld_i;
            if (fin_vld_i) begin
                data_q <= data_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;
    assign ovf_o  = ovf_q;

endmodule

// File: rtl/mac_psum_acc.sv
// Channel partial-sum accumulator: sums cfg_num_ch MAC results plus a bias per group,
// then hands the finished sum to the requant stage.
module mac_psum_acc
    import mac_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic [7:0]               cfg_num_ch,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic signed [BIAS_W-1:0] bias_i,
    input  logic                     vld_i,
    input  logic signed [ACC_W-1:0]  acc_i,
    output logic signed [OUT_W-1:0]  data_o,
    output logic                     vld_o,
    output logic                     ovf_o,
    output logic                     busy_o
);

    acc_state_e               state_q;
    logic [7:0]               ch_cnt_q;
    logic [7:0]               grp_num_q;
    rq_cfg_t                  grp_cfg_q;
    logic signed [PSUM_W-1:0] psum_q;
    logic                     fin_vld_q;
    logic [7:0]               eff_num;

    assign eff_num = (cfg_num_ch == 8'd0) ? 8'd1 : cfg_num_ch;

    // The requant stage samples psum_q/grp_cfg_q while fin_vld_q is high, i.e. before a
    // back-to-back first beat's new values become visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            ch_cnt_q  <= '0;
            grp_num_q <= '0;
            grp_cfg_q <= '0;
            psum_q    <= '0;
            fin_vld_q <= 1'b0;
        end else begin
            fin_vld_q <= 1'b0;
            if (vld_i) begin
                case (state_q)
                    ST_IDLE: begin
                        psum_q    <= PSUM_W'(bias_i) + PSUM_W'(acc_i);
                        grp_num_q <= eff_num;
                        grp_cfg_q <= '{shift: cfg_shift, relu: cfg_relu};
                        if (eff_num == 8'd1) begin
                            ch_cnt_q  <= '0;
                            fin_vld_q <= 1'b1;
                        end else begin
                            ch_cnt_q <= 8'd1;
                            state_q  <= ST_ACCUM;
                        end
                    end
                    ST_ACCUM: begin
                        psum_q <= psum_q + PSUM_W'(acc_i);
                        if (ch_cnt_q + 8'd1 == grp_num_q) begin
                            ch_cnt_q  <= '0;
                            state_q   <= ST_IDLE;
                            fin_vld_q <= 1'b1;
                        end else begin
                            ch_cnt_q <= ch_cnt_q + 8'd1;
                        end
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // A first beat arriving right after a last beat keeps busy_o asserted.
    assign busy_o = (ch_cnt_q != 8'd0) || vld_i;

    psum_requant u_requant (
        .clk       (clk),
        .rst       (rst),
        .fin_vld_i (fin_vld_q),
        .psum_i    (psum_q),
        .cfg_i     (grp_cfg_q),
        .data_o    (data_o),
        .vld_o     (vld_o),
        .ovf_o     (ovf_o)
    );

endmodule

// File: tb/tb_mac_psum_acc.sv
// Directed bench for mac_psum_acc: hand-computed groups checked with immediate assertions.
module tb_mac_psum_acc;
    import mac_pkg::*;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [7:0]               cfg_num_ch;
    logic [4:0]               cfg_shift;
    logic                     cfg_relu;
    logic signed [BIAS_W-1:0] bias_i;
    logic                     vld_i;
    logic signed [ACC_W-1:0]  acc_i;
    logic signed [OUT_W-1:0]  data_o;
    logic                     vld_o;
    logic                     ovf_o;
    logic                     busy_o;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    always #5 clk = ~clk;

    always @(negedge clk) if (vld_o === 1'b1) pulses++;

    mac_psum_acc dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_num_ch (cfg_num_ch),
        .cfg_shift  (cfg_shift),
        .cfg_relu   (cfg_relu),
        .bias_i     (bias_i),
        .vld_i      (vld_i),
        .acc_i      (acc_i),
        .data_o     (data_o),
        .vld_o      (vld_o),
        .ovf_o      (ovf_o),
        .busy_o     (busy_o)
    );

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic signed [ACC_W-1:0] a);
        vld_i = 1'b1;
        acc_i = a;
        tick();
        vld_i = 1'b0;
        acc_i = '0;
    endtask

    // Called in the cycle after the last beat: no output yet, pulse next cycle, then hold.
    task automatic expect_out(input string tag, input int exp_data, input logic exp_ovf);
        chk({tag, "_early"}, 32'(vld_o), 0);
        tick();
        chk({tag, "_vld"}, 32'(vld_o), 1);
        chk({tag, "_data"}, 32'(data_o), exp_data);
        chk({tag, "_ovf"}, 32'(ovf_o), 32'(exp_ovf));
        tick();
        chk({tag, "_pulse"}, 32'(vld_o), 0);
        chk({tag, "_hold"}, 32'(data_o), exp_data);
    endtask

    task automatic cfg(input int n, input int sh, input logic relu, input int bias);
        cfg_num_ch = 8'(n);
        cfg_shift  = 5'(sh);
        cfg_relu   = relu;
        bias_i     = BIAS_W'(bias);
    endtask

    initial begin
        int p0;
        rst = 1'b1;
        vld_i = 1'b0;
        acc_i = '0;
        cfg(1, 0, 1'b0, 0);
        tick();
        chk("rst_data", 32'(data_o), 0);
        chk("rst_vld", 32'(vld_o), 0);
        chk("rst_ovf", 32'(ovf_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        rst = 1'b0;
        tick();

        // Single channel
        beat(5);
        expect_out("single", 5, 1'b0);

        // cfg_num_ch = 0 acts as 1
        cfg(0, 0, 1'b0, 0);
        beat(7);
        expect_out("num0", 7, 1'b0);

        // Gapped group with rounding: 976 + 8 >>> 4 = 61
        cfg(4, 4, 1'b0, -24);
        beat(100);
        chk("gap_busy", 32'(busy_o), 1);
        tick(); tick();
        chk("gap_busy_idle", 32'(busy_o), 1);
        beat(200);
        tick();
        beat(300);
        tick(); tick(); tick();
        beat(400);
        expect_out("gap", 61, 1'b0);

        cfg(1, 4, 1'b0, 0);
        beat(-24);
        expect_out("neg_round", -1, 1'b0);

        // Saturation
        cfg(2, 0, 1'b0, 0);
        beat(100000);
        beat(100000);
        expect_out("sat_pos", 127, 1'b1);
        cfg(1, 0, 1'b0, 0);
        beat(-50000);
        expect_out("sat_neg", -128, 1'b1);
        cfg(1, 0, 1'b1, 0);
        beat(-50000);
        expect_out("relu", 0, 1'b0);

        // Back-to-back groups of two: 10+20 then 30+40
        cfg(2, 0, 1'b0, 0);
        vld_i = 1'b1; acc_i = 10; #1;
        chk("b2b_busy0", 32'(busy_o), 1);
        @(posedge clk); #1;
        acc_i = 20; #1;
        chk("b2b_busy1", 32'(busy_o), 1);
        @(posedge clk); #1;
        acc_i = 30; #1;
        chk("b2b_busy2", 32'(busy_o), 1);
        chk("b2b_vld2", 32'(vld_o), 0);
        @(posedge clk); #1;
        acc_i = 40; #1;
        chk("b2b_busy3", 32'(busy_o), 1);
        chk("b2b_vld3", 32'(vld_o), 1);
        chk("b2b_data3", 32'(data_o), 30);
        @(posedge clk); #1;
        vld_i = 1'b0; acc_i = '0; #1;
        chk("b2b_vld4", 32'(vld_o), 0);
        chk("b2b_busy4", 32'(busy_o), 0);
        @(posedge clk); #1;
        chk("b2b_vld5", 32'(vld_o), 1);
        chk("b2b_data5", 32'(data_o), 70);
        tick();

        // Reset mid-group drops the partial sum
        cfg(3, 0, 1'b0, 0);
        p0 = pulses;
        beat(50);
        beat(50);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_busy", 32'(busy_o), 0);
        tick();
        beat(1);
        beat(2);
        beat(3);
        expect_out("abort", 6, 1'b0);
        chk("abort_pulses", pulses - p0, 1);

        // Config latched on the first beat
        cfg(2, 0, 1'b0, 0);
        beat(8);
        cfg_shift = 5'd3;
        beat(8);
        expect_out("cfg_latch", 16, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
